// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: load-use stalls, branch flushes, data-memory waits.
// Optional perf counters are built when PIPE_HAZARD_CTRL_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rd,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_uses_rs2,
  input  logic             branch_taken_ex,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             pc_sel_target,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_bubble,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             mem_wb_bubble,
  output logic             mem_err,
`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt,
  output logic [CNT_W-1:0] perf_wait_cnt,
`endif
  output logic [1:0]       ctrl_state
);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [3:0]  LP_STALL_RELOAD = 4'(STALL_CYCLES - 1);
  localparam logic [15:0] LP_TIMEOUT      = 16'(MEM_TIMEOUT);

  if (STALL_CYCLES < 1 || STALL_CYCLES > 15) begin : g_bad_stall
    $error("STALL_CYCLES out of range");
  end
  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 65535) begin : g_bad_timeout
    $error("MEM_TIMEOUT out of range");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be positive");
  end

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_stall_cnt;
  logic [3:0]  w_stall_cnt_next;
  logic [15:0] r_wait_cnt;
  logic        r_mem_err;

  logic w_freeze, w_lu, w_stall_bubble;
  logic w_pc_en, w_pc_sel, w_if_id_en, w_flush, w_id_ex_en, w_id_ex_bub;
  logic w_ex_mem_en, w_mem_wb_en, w_mem_wb_bub;

  assign w_freeze = dmem_req & ~dmem_ready;
  assign w_lu     = id_ex_memread & (id_ex_rd != 5'd0) &
                    ((id_ex_rd == if_id_rs1) | (if_id_uses_rs2 & (id_ex_rd == if_id_rs2)));

  always_comb begin
    w_pc_en          = 1'b1;
    w_pc_sel         = 1'b0;
    w_if_id_en       = 1'b1;
    w_flush          = 1'b0;
    w_id_ex_en       = 1'b1;
    w_id_ex_bub      = 1'b0;
    w_ex_mem_en      = 1'b1;
    w_mem_wb_en      = 1'b1;
    w_mem_wb_bub     = 1'b0;
    w_stall_bubble   = 1'b0;
    w_stall_cnt_next = r_stall_cnt;
    w_state_next     = RUN;
    if (w_freeze) begin
      w_pc_en      = 1'b0;
      w_if_id_en   = 1'b0;
      w_id_ex_en   = 1'b0;
      w_ex_mem_en  = 1'b0;
      w_mem_wb_en  = 1'b0;
      w_mem_wb_bub = 1'b1;
      w_state_next = WAIT;
    end else if (branch_taken_ex) begin
      w_pc_sel         = 1'b1;
      w_flush          = 1'b1;
      w_id_ex_bub      = 1'b1;
      w_stall_cnt_next = 4'd0;
    end else begin
      // Leaving WAIT with a stall pending only bubbles if the hazard is still live.
      if (r_state == STALL) begin
        w_stall_bubble   = 1'b1;
        w_stall_cnt_next = r_stall_cnt - 4'd1;
      end else if (w_lu) begin
        w_stall_bubble = 1'b1;
        if (r_stall_cnt == 4'd0) w_stall_cnt_next = LP_STALL_RELOAD;
      end
      if (w_stall_bubble) begin
        w_pc_en     = 1'b0;
        w_if_id_en  = 1'b0;
        w_id_ex_bub = 1'b1;
      end
      w_state_next = (w_stall_cnt_next != 4'd0) ? STALL : RUN;
    end
  end

  assign pc_en         = ~arst & w_pc_en;
  assign pc_sel_target = ~arst & w_pc_sel;
  assign if_id_en      = ~arst & w_if_id_en;
  assign if_id_flush   = ~arst & w_flush;
  assign id_ex_en      = ~arst & w_id_ex_en;
  assign id_ex_bubble  = ~arst & w_id_ex_bub;
  assign ex_mem_en     = ~arst & w_ex_mem_en;
  assign mem_wb_en     = ~arst & w_mem_wb_en;
  assign mem_wb_bubble = ~arst & w_mem_wb_bub;
  assign mem_err       = r_mem_err;
  assign ctrl_state    = r_state;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state     <= RUN;
      r_stall_cnt <= 4'd0;
      r_wait_cnt  <= 16'd0;
      r_mem_err   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_stall_cnt <= w_stall_cnt_next;
      if (w_freeze) begin
        if (r_wait_cnt != LP_TIMEOUT) r_wait_cnt <= r_wait_cnt + 16'd1;
        // Flag on the edge where the saturating count reaches the timeout.
        if (r_wait_cnt >= LP_TIMEOUT - 16'd1) r_mem_err <= 1'b1;
      end else begin
        r_wait_cnt <= 16'd0;
      end
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_perf_stall, r_perf_flush, r_perf_wait;
  logic             w_flush_evt;

  assign w_flush_evt = branch_taken_ex & ~w_freeze;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
      r_perf_wait  <= '0;
    end else begin
      if (w_stall_bubble && !(&r_perf_stall)) r_perf_stall <= r_perf_stall + 1'b1;
      if (w_flush_evt && !(&r_perf_flush))    r_perf_flush <= r_perf_flush + 1'b1;
      if (w_freeze && !(&r_perf_wait))        r_perf_wait  <= r_perf_wait + 1'b1;
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
  assign perf_wait_cnt  = r_perf_wait;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a driver pushes expected outputs from a
// behavioural model, a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;
  localparam int SC = 3;
  localparam int TO = 3;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic id_ex_memread = 1'b0;
  logic [4:0] id_ex_rd = '0, if_id_rs1 = '0, if_id_rs2 = '0;
  logic if_id_uses_rs2 = 1'b0, branch_taken_ex = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic pc_en, pc_sel_target, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
  logic ex_mem_en, mem_wb_en, mem_wb_bubble, mem_err;
  logic [1:0] ctrl_state;
`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
  logic [CW-1:0] perf_stall_cnt, perf_flush_cnt, perf_wait_cnt;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.STALL_CYCLES(SC), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .arst(arst), .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_uses_rs2(if_id_uses_rs2),
    .branch_taken_ex(branch_taken_ex), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .pc_sel_target(pc_sel_target), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .mem_wb_bubble(mem_wb_bubble),
    .mem_err(mem_err),
`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_wait_cnt(perf_wait_cnt),
`endif
    .ctrl_state(ctrl_state)
  );

  // pc_en, pc_sel, if_id_en, flush, id_ex_en, id_ex_bub, ex_mem_en, mem_wb_en, mem_wb_bub, mem_err, state
  typedef logic [11:0] obs_t;
  obs_t exp_q[$];
  string tag_q[$];
  int checks = 0;
  int errors = 0;

  // Model: pipeline is either waiting on memory, owing some bubble cycles, or running.
  int m_bubbles_owed = 0;
  bit m_in_wait = 0;
  int m_wait_len = 0;
  bit m_err = 0;

  function automatic obs_t model_step(input bit r, input bit mr, input int rd, input int rs1,
                                      input int rs2, input bit u2, input bit br,
                                      input bit rq, input bit rdy);
    bit pe, ps, ie, fl, de, db, xe, we, wb, hz, owing;
    int st;
    if (r) begin
      m_bubbles_owed = 0; m_in_wait = 0; m_wait_len = 0; m_err = 0;
      return '0;
    end
    st = m_in_wait ? 2 : (m_bubbles_owed > 0 ? 1 : 0);
    model_step[2] = m_err;
    model_step[1:0] = st[1:0];
    hz = mr && rd != 0 && (rd == rs1 || (u2 && rd == rs2));
    {pe, ps, ie, fl, de, db, xe, we, wb} = 9'b1_0_1_0_1_0_1_1_0;
    if (rq && !rdy) begin
      {pe, ie, de, xe, we, wb} = 6'b000001;
      m_in_wait = 1;
      m_wait_len = (m_wait_len + 1 > TO) ? TO : m_wait_len + 1;
      if (m_wait_len == TO) m_err = 1;
    end else begin
      owing = !m_in_wait && m_bubbles_owed > 0;
      m_in_wait = 0;
      m_wait_len = 0;
      if (br) begin
        ps = 1; fl = 1; db = 1;
        m_bubbles_owed = 0;
      end else if (owing || hz) begin
        pe = 0; ie = 0; db = 1;
        if (owing) m_bubbles_owed--;
        else if (m_bubbles_owed == 0) m_bubbles_owed = SC - 1;
      end
    end
    model_step[11:3] = {pe, ps, ie, fl, de, db, xe, we, wb};
  endfunction

  task automatic step(input string tag, input bit r, input bit mr, input int rd, input int rs1,
                      input int rs2, input bit u2, input bit br, input bit rq, input bit rdy);
    @(posedge clk);
    #1;
    arst = r; id_ex_memread = mr; id_ex_rd = 5'(rd); if_id_rs1 = 5'(rs1);
    if_id_rs2 = 5'(rs2); if_id_uses_rs2 = u2; branch_taken_ex = br;
    dmem_req = rq; dmem_ready = rdy;
    exp_q.push_back(model_step(r, mr, rd, rs1, rs2, u2, br, rq, rdy));
    tag_q.push_back(tag);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e, a;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {pc_en, pc_sel_target, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
           ex_mem_en, mem_wb_en, mem_wb_bubble, mem_err, ctrl_state};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s @%0t: got %b, expected %b", t, $time, a, e);
      end else begin
        $display("txn %s @%0t: outputs %b", t, $time, a);
      end
    end
  end

  initial begin
    step("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("reset", 1, 1, 5, 5, 0, 0, 1, 1, 0);
    step("normal", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Load-use: SC=3 gives three bubble cycles, then run.
    step("lu_rs1", 0, 1, 5, 5, 0, 0, 0, 0, 0);
    step("stall1", 0, 1, 5, 5, 0, 0, 0, 0, 0);
    step("stall2", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("after_stall", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rd_zero", 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step("lu_rs2", 0, 1, 7, 1, 7, 1, 0, 0, 0);
    step("rs2_unused", 0, 1, 7, 1, 7, 0, 0, 0, 0);
    // Branch in the second stall cycle aborts the stall.
    step("lu", 0, 1, 5, 5, 0, 0, 0, 0, 0);
    step("stall_branch", 0, 1, 5, 5, 0, 0, 1, 0, 0);
    step("post_branch", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Four frozen cycles, ready on the fifth.
    for (int i = 0; i < 4; i++) step("freeze", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("ready", 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("post_ready", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("reset_clr", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Timeout: error rises on the third wait edge and stays.
    for (int i = 0; i < 5; i++) step("timeout", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("ready_err", 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("err_sticky", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("wait_again", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("arst_mid_wait", 1, 0, 0, 0, 0, 0, 0, 1, 0);
    step("after_arst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("branch_and_lu", 0, 1, 5, 5, 0, 0, 1, 0, 0);
    step("post_both", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Stall interrupted by a memory wait, then resumed.
    step("lu_w", 0, 1, 3, 3, 0, 0, 0, 0, 0);
    step("stall_freeze", 0, 1, 3, 3, 0, 0, 0, 1, 0);
    step("release_lu", 0, 1, 3, 3, 0, 0, 0, 1, 1);
    step("resume", 0, 1, 3, 3, 0, 0, 0, 0, 0);
    step("resume2", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      bit r, mr, u2, br, rq, rdy;
      r   = ($urandom_range(63) == 0);
      mr  = $urandom_range(1);
      u2  = $urandom_range(1);
      br  = ($urandom_range(6) == 0);
      rq  = ($urandom_range(9) < 3);
      rdy = $urandom_range(1);
      step("rand", r, mr, int'($urandom_range(3)), int'($urandom_range(3)),
           int'($urandom_range(3)), u2, br, rq, rdy);
    end

    step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
